// File: rtl/cp0_exception_ctrl.sv
// CP0 exception/interrupt/ERET sequencer: serialises the CP0 updates over one write port,
// then stalls, flushes and redirects the pipeline.
module cp0_exception_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'hBFC00380)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slot_valid,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic [WIDTH-1:0] exc_badvaddr,
    input  logic             exc_bd,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] cause_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [WIDTH-1:0] cp0_wdata,
    output logic             stall_req,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             busy
);

    localparam logic [4:0] REG_BADV   = 5'd8;
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] CODE_ADEL  = 5'd4;
    localparam logic [4:0] CODE_ADES  = 5'd5;
    localparam logic [WIDTH-1:0] EXL_MASK = WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_BADV,
        W_STATUS,
        W_ERET,
        REDIRECT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] badv_q;
    logic             bd_q;
    logic [4:0]       code_q;

    logic int_pending;
    logic accept;
    logic take_eret;
    logic in_write;

    // Interrupt only when enabled, unmasked and not already at exception level.
    assign int_pending = (|(cause_in[15:8] & status_in[15:8])) & status_in[0] & ~status_in[1];
    assign accept      = (state == IDLE) & slot_valid & (int_pending | exc_valid | eret_valid);
    assign take_eret   = ~int_pending & ~exc_valid & eret_valid;
    assign in_write    = (state == W_EPC) | (state == W_CAUSE) | (state == W_BADV) |
                         (state == W_STATUS) | (state == W_ERET);

    // Stall starts in the accept cycle itself and releases when the redirect is issued.
    assign stall_req = ~rst & (accept | in_write);

    // Sequencer state plus registered flush/redirect/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc_q           <= '0;
            badv_q         <= '0;
            bd_q           <= 1'b0;
            code_q         <= 5'd0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc_q   <= exc_pc;
                        badv_q <= exc_badvaddr;
                        bd_q   <= exc_bd;
                        code_q <= int_pending ? 5'd0 : (exc_valid ? exc_code : 5'd0);
                        state  <= take_eret ? W_ERET : W_EPC;
                        flush  <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                W_EPC:   state <= W_CAUSE;
                W_CAUSE: state <= ((code_q == CODE_ADEL) || (code_q == CODE_ADES)) ? W_BADV : W_STATUS;
                W_BADV:  state <= W_STATUS;
                W_STATUS: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= EXC_VECTOR;
                end
                W_ERET: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= epc_in;
                end
                REDIRECT: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= '0;
                    flush          <= 1'b0;
                    busy           <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write port decoded from the state register; Status/Cause are read live so
    // earlier writes in the sequence are already reflected.
    always_comb begin
        cp0_we    = 1'b0;
        cp0_waddr = 5'd0;
        cp0_wdata = '0;
        case (state)
            W_EPC: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_EPC;
                cp0_wdata = bd_q ? (pc_q - WIDTH'(4)) : pc_q;
            end
            W_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_CAUSE;
                cp0_wdata = {bd_q, cause_in[WIDTH-2:7], code_q, 2'b00};
            end
            W_BADV: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_BADV;
                cp0_wdata = badv_q;
            end
            W_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_STATUS;
                cp0_wdata = status_in | EXL_MASK;
            end
            W_ERET: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_STATUS;
                cp0_wdata = status_in & ~EXL_MASK;
            end
            default: ;
        endcase
    end

    logic unused_cause_bits;
    assign unused_cause_bits = ^{cause_in[WIDTH-1], cause_in[6:0]};

endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
- Sequences all exception, interrupt and ERET updates into the CP0 register file over its single write port (we/waddr/wdata).
- Sits between the MEM stage commit point and CP0.
- Prioritises interrupts over synchronous exceptions, stalls the pipeline during the update, and issues one flush/redirect pulse to the fetch stage.

Parameters:
- WIDTH, 32, datapath width.
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- slot_valid  in  1  a real (non-bubble) instruction occupies the MEM commit slot this cycle
- exc_valid  in  1  that instruction raised a synchronous exception
- exc_code  in  5  ExcCode of the synchronous exception
- exc_pc  in  WIDTH  PC of the slot instruction
- exc_badvaddr  in  WIDTH  faulting virtual address
- exc_bd  in  1  slot instruction is in a branch delay slot
- eret_valid  in  1  slot instruction is ERET
- status_in  in  WIDTH  current CP0 Status (IM=15:8, EXL=1, IE=0)
- cause_in  in  WIDTH  current CP0 Cause (IP=15:8)
- epc_in  in  WIDTH  current CP0 EPC
- cp0_we  out  1  CP0 write enable
- cp0_waddr  out  5  CP0 register number
- cp0_wdata  out  WIDTH  CP0 write data
- stall_req  out  1  freeze the pipeline
- flush  out  1  kill all in-flight instructions
- redirect_valid  out  1  fetch must jump to redirect_pc
- redirect_pc  out  WIDTH  new fetch PC
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM goes to IDLE. cp0_we, cp0_waddr, cp0_wdata, stall_req, flush, redirect_valid, redirect_pc, busy all 0. Applies immediately and asynchronously.
- int_pending = |(cause_in[15:8] & status_in[15:8]) & status_in[0] & ~status_in[1].
- Accept, evaluated only in IDLE with slot_valid=1. Priority order:
  - int_pending: code 0. Wins over exc_valid and eret_valid.
  - exc_valid: exc_code. Wins over eret_valid.
  - eret_valid.
- On accept, the accept cycle is cycle 0:
  - stall_req=1 combinationally in cycle 0.
  - Latch exc_pc, exc_badvaddr, exc_bd, the selected code, and the kind (EXC or ERET).
- Exception FSM path: IDLE -> W_EPC -> W_CAUSE -> [W_BADV] -> W_STATUS -> REDIRECT -> IDLE. One state per cycle.
  - W_EPC: waddr 14, wdata = bd ? pc-4 : pc.
  - W_CAUSE: waddr 13, wdata = {bd, cause_in[30:7], code, 2'b00}.
  - W_BADV: waddr 8, wdata = badvaddr. Entered only when code is 4 (AdEL) or 5 (AdES); otherwise skipped.
  - W_STATUS: waddr 12, wdata = status_in | 32'h2 (EXL set).
  - REDIRECT: redirect_valid=1 and redirect_pc=EXC_VECTOR, for exactly one cycle. cp0_we=0.
- ERET FSM path: IDLE -> W_ERET -> REDIRECT -> IDLE.
  - W_ERET: waddr 12, wdata = status_in & ~32'h2.
  - REDIRECT: redirect_pc = epc_in, sampled in the W_ERET cycle.
- cp0_we=1 exactly in the W_* states. waddr and wdata are registered-state decoded and hold 0 when we=0.
- Outputs across cycles 1..REDIRECT:
  - flush=1 and stall_req=1.
  - busy=1 in every non-IDLE state.
  - In REDIRECT, stall_req drops to 0 and flush stays 1.
- Latency:
  - Exception without BadVAddr: redirect in cycle 4.
  - AdEL/AdES: redirect in cycle 5.
  - ERET: redirect in cycle 2.
- slot_valid, exc_valid and eret_valid are ignored while busy. No queuing: the pipeline is stalled, and the flush discards the instruction.
- status_in and cause_in are sampled in the write cycle. This makes CP0 updates from earlier writes in the sequence visible.
- slot_valid=0: no accept, even if int_pending is set. An interrupt waits for a real instruction, so EPC stays valid.
- exc_valid=1 with eret_valid=1: take the exception.
- Reset mid-sequence: abort to IDLE with no redirect. A partial CP0 update is acceptable because CP0 also resets.

Test Plan:
- Syscall: slot_valid=1, exc_valid=1, exc_code=8, exc_pc=0x80001000, bd=0 -> writes, in order:
  - cycle 1: (14, 0x80001000)
  - cycle 2: (13, code field 8)
  - cycle 3: (12, status_in|2)
  - cycle 4: redirect_valid=1 with pc 0xBFC00380
  - stall_req high in cycles 0-3.
- AdEL in delay slot: exc_code=4, pc=0x80002004, bd=1, badvaddr=0x00000003 -> EPC write 0x80002000, Cause[31]=1, (8, 0x00000003) in cycle 3, redirect in cycle 5.
- Interrupt priority: cause_in[15:8]=0x80, status_in=0x00008001, exc_valid=1 code 10 -> Cause ExcCode=0, exc_code ignored. Same stimulus with status_in EXL=1 -> exception code 10 taken instead.
- ERET: eret_valid=1, epc_in=0x80003000, status_in=0x00008003 -> cycle 1 writes (12, 0x00008001), cycle 2 redirect_pc=0x80003000.
- Busy lockout and reset abort: assert a second exc_valid in cycle 2 -> ignored, and the sequence completes unchanged. Assert rst in cycle 2 of a new sequence -> all outputs 0 at once, no redirect, FSM back in IDLE.
